// File: rtl/ysyx_25030085_pkg.sv
// Shared parameters and types for the writeback arbiter slice.
package ysyx_25030085_pkg;

  localparam int XLEN   = 32;
  localparam int NREG   = 32;
  localparam int REG_AW = 5;

  // Register-dump sequencer states.
  typedef enum logic [1:0] {
    DS_IDLE  = 2'd0,
    DS_DUMP  = 2'd1,
    DS_DRAIN = 2'd2
  } dump_state_e;

endpackage

// File: rtl/ysyx_25030085_scoreboard.sv
// Load scoreboard: one busy bit per architectural register.
// A bit is set when a load issues and cleared when its LSU writeback
// completes. The hazard check stalls any issue that touches a busy register
// and any load while another load is outstanding.
module ysyx_25030085_scoreboard
  import ysyx_25030085_pkg::*;
#(
  parameter int NREG = ysyx_25030085_pkg::NREG
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              iss_valid,
  input  logic              iss_load,
  input  logic [REG_AW-1:0] iss_rs1,
  input  logic [REG_AW-1:0] iss_rs2,
  input  logic [REG_AW-1:0] iss_rd,
  input  logic              fsm_idle,
  input  logic              clr_en,
  input  logic [REG_AW-1:0] clr_idx,
  output logic              iss_stall
);

  logic [NREG-1:0] busy_q;
  logic [NREG-1:0] busy_d;
  logic            hit_rs1;
  logic            hit_rs2;
  logic            hit_rd;
  logic            set_en;

  // Look up the busy bit of each issue operand; index 0 is never busy.
  always_comb begin
    hit_rs1 = 1'b0;
    hit_rs2 = 1'b0;
    hit_rd  = 1'b0;
    for (int i = 1; i < NREG; i++) begin
      hit_rs1 = hit_rs1 | (busy_q[i] & (iss_rs1 == REG_AW'(i)));
      hit_rs2 = hit_rs2 | (busy_q[i] & (iss_rs2 == REG_AW'(i)));
      hit_rd  = hit_rd  | (busy_q[i] & (iss_rd  == REG_AW'(i)));
    end
  end

  assign iss_stall = iss_valid &
                     (hit_rs1 | hit_rs2 | hit_rd | (iss_load & (|busy_q)) | ~fsm_idle);

  assign set_en = iss_valid & ~iss_stall & iss_load & (iss_rd != '0);

  // Next busy vector: clear from the LSU writeback, then set from issue so
  // a same-index set overrides the clear.
  always_comb begin
    busy_d = busy_q;
    for (int i = 1; i < NREG; i++) begin
      if (clr_en && (clr_idx == REG_AW'(i))) busy_d[i] = 1'b0;
      if (set_en && (iss_rd == REG_AW'(i)))  busy_d[i] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  // Busy-bit register.
  always_ff @(posedge clk) begin
    if (rst) busy_q <= '0;
    else     busy_q <= busy_d;
  end

endmodule

// File: rtl/ysyx_25030085_wb_arbiter.sv
// Register-file write-port arbiter with load scoreboard and register dump.
// Handshakes: a transfer completes on any cycle where valid and ready are
// both high; valid may be held while ready is low and the payload must stay
// stable until the transfer completes.
// The LSU has fixed priority over the EXU. While a dump is running both
// writeback channels are held off so the dump sees a consistent snapshot.
module ysyx_25030085_wb_arbiter
  import ysyx_25030085_pkg::*;
#(
  parameter int XLEN = ysyx_25030085_pkg::XLEN,
  parameter int NREG = ysyx_25030085_pkg::NREG
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              exu_wb_valid,
  input  logic [REG_AW-1:0] exu_wb_rd,
  input  logic [XLEN-1:0]   exu_wb_data,
  output logic              exu_wb_ready,
  input  logic              lsu_wb_valid,
  input  logic [REG_AW-1:0] lsu_wb_rd,
  input  logic [XLEN-1:0]   lsu_wb_data,
  output logic              lsu_wb_ready,
  input  logic              iss_valid,
  input  logic              iss_load,
  input  logic [REG_AW-1:0] iss_rs1,
  input  logic [REG_AW-1:0] iss_rs2,
  input  logic [REG_AW-1:0] iss_rd,
  output logic              iss_stall,
  output logic              rf_we,
  output logic [REG_AW-1:0] rf_waddr,
  output logic [XLEN-1:0]   rf_wdata,
  output logic [REG_AW-1:0] dump_raddr,
  input  logic [XLEN-1:0]   rf_rdata,
  input  logic              dump_req,
  output logic              dump_busy,
  output logic              dump_valid,
  output logic [REG_AW-1:0] dump_idx,
  output logic [XLEN-1:0]   dump_data,
  output dump_state_e       dbg_state
);

  localparam logic [REG_AW-1:0] LAST_IDX = REG_AW'(NREG - 1);

  dump_state_e       state_q;
  dump_state_e       state_d;
  logic [REG_AW-1:0] cnt_q;
  logic [REG_AW-1:0] cnt_d;
  logic              state_idle;
  logic              lsu_fire;
  logic              exu_fire;
  logic              dv_q;
  logic [REG_AW-1:0] di_q;
  logic [XLEN-1:0]   dd_q;

  assign state_idle   = (state_q == DS_IDLE);
  assign lsu_wb_ready = state_idle;
  assign exu_wb_ready = state_idle & ~lsu_wb_valid;
  assign lsu_fire     = lsu_wb_valid & lsu_wb_ready;
  assign exu_fire     = exu_wb_valid & exu_wb_ready;

  // Steer the winning writeback onto the register-file port; x0 is dropped.
  always_comb begin
    rf_we    = 1'b0;
    rf_waddr = '0;
    rf_wdata = '0;
    if (lsu_fire) begin
      rf_we    = ~rst & (lsu_wb_rd != '0);
      rf_waddr = lsu_wb_rd;
      rf_wdata = lsu_wb_data;
    end else if (exu_fire) begin
      rf_we    = ~rst & (exu_wb_rd != '0);
      rf_waddr = exu_wb_rd;
      rf_wdata = exu_wb_data;
    end
  end

  // Dump sequencer state and index counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= DS_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Dump sequencer transitions: walk every register once, then one drain
  // cycle to flush the registered read stage.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      DS_IDLE: begin
        if (dump_req) begin
          state_d = DS_DUMP;
          cnt_d   = '0;
        end
      end
      DS_DUMP: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST_IDX) begin
          state_d = DS_DRAIN;
          cnt_d   = '0;
        end
      end
      DS_DRAIN: state_d = DS_IDLE;
      default:  state_d = DS_IDLE;
    endcase
  end

  assign dump_raddr = (state_q == DS_DUMP) ? cnt_q : '0;
  assign dump_busy  = ~state_idle;
  assign dbg_state  = state_q;

  // Register the read data so each beat appears one cycle after its address.
  always_ff @(posedge clk) begin
    if (rst) begin
      dv_q <= 1'b0;
      di_q <= '0;
      dd_q <= '0;
    end else begin
      dv_q <= (state_q == DS_DUMP);
      di_q <= (state_q == DS_DUMP) ? cnt_q : '0;
      dd_q <= (state_q == DS_DUMP) ? rf_rdata : '0;
    end
  end

  assign dump_valid = dv_q & ~rst;
  assign dump_idx   = rst ? '0 : di_q;
  assign dump_data  = rst ? '0 : dd_q;

  ysyx_25030085_scoreboard #(
    .NREG (NREG)
  ) u_scoreboard (
    .clk       (clk),
    .rst       (rst),
    .iss_valid (iss_valid),
    .iss_load  (iss_load),
    .iss_rs1   (iss_rs1),
    .iss_rs2   (iss_rs2),
    .iss_rd    (iss_rd),
    .fsm_idle  (state_idle),
    .clr_en    (lsu_fire),
    .clr_idx   (lsu_wb_rd),
    .iss_stall (iss_stall)
  );

endmodule

// File: tb/tb_ysyx_25030085_wb_arbiter.sv
// Bench for the writeback arbiter: directed scenarios plus random traffic,
// checked against a cycle-level reference model kept in the bench.
module tb_ysyx_25030085_wb_arbiter;
  import ysyx_25030085_pkg::*;

  // ---------------- clock / reset / DUT ----------------
  logic              clk = 1'b0;
  logic              rst;
  logic              exu_wb_valid, lsu_wb_valid, iss_valid, iss_load, dump_req;
  logic [4:0]        exu_wb_rd, lsu_wb_rd, iss_rs1, iss_rs2, iss_rd;
  logic [31:0]       exu_wb_data, lsu_wb_data, rf_rdata;
  logic              exu_wb_ready, lsu_wb_ready, iss_stall, rf_we;
  logic [4:0]        rf_waddr, dump_raddr, dump_idx;
  logic [31:0]       rf_wdata, dump_data;
  logic              dump_busy, dump_valid;
  dump_state_e       dbg_state;

  always #5 clk = ~clk;

  ysyx_25030085_wb_arbiter dut (
    .clk(clk), .rst(rst),
    .exu_wb_valid(exu_wb_valid), .exu_wb_rd(exu_wb_rd), .exu_wb_data(exu_wb_data),
    .exu_wb_ready(exu_wb_ready),
    .lsu_wb_valid(lsu_wb_valid), .lsu_wb_rd(lsu_wb_rd), .lsu_wb_data(lsu_wb_data),
    .lsu_wb_ready(lsu_wb_ready),
    .iss_valid(iss_valid), .iss_load(iss_load), .iss_rs1(iss_rs1), .iss_rs2(iss_rs2),
    .iss_rd(iss_rd), .iss_stall(iss_stall),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .dump_raddr(dump_raddr), .rf_rdata(rf_rdata),
    .dump_req(dump_req), .dump_busy(dump_busy), .dump_valid(dump_valid),
    .dump_idx(dump_idx), .dump_data(dump_data), .dbg_state(dbg_state)
  );

  // Register file environment: one write port, combinational debug read.
  logic [31:0] mem [32];
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) mem[i] <= '0;
    end else if (rf_we && rf_waddr != 5'd0) begin
      mem[rf_waddr] <= rf_wdata;
    end
  end
  assign rf_rdata = mem[dump_raddr];

  // ---------------- scoreboard state ----------------
  int          total = 0;
  int          bad   = 0;
  int          cyc   = 0;
  int          last_beat_cyc = 0;
  logic [36:0] exp_wr_q[$];
  logic [36:0] exp_dump_q[$];

  // Reference model: outstanding loads, shadow register contents, dump timer.
  logic [4:0]  pend[$];
  logic [31:0] shadow [32];
  int          dump_left = 0;

  // Requested stimulus for the next cycle.
  logic        d_rst, d_exu_v, d_lsu_v, d_iv, d_load, d_dump;
  logic [4:0]  d_exu_rd, d_lsu_rd, d_rs1, d_rs2, d_rd;
  logic [31:0] d_exu_d, d_lsu_d;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic bit is_busy(input logic [4:0] r);
    foreach (pend[k]) if (r != 5'd0 && pend[k] == r) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit any_busy();
    foreach (pend[k]) if (pend[k] != 5'd0) return 1'b1;
    return 1'b0;
  endfunction

  // ---------------- driver: one clock cycle ----------------
  task automatic step();
    bit idle, lsu_go, exu_go, exp_stall;
    idle   = (dump_left == 0);
    rst          = d_rst;
    exu_wb_valid = d_exu_v;  exu_wb_rd = d_exu_rd;  exu_wb_data = d_exu_d;
    lsu_wb_valid = d_lsu_v;  lsu_wb_rd = d_lsu_rd;  lsu_wb_data = d_lsu_d;
    iss_valid    = d_iv;     iss_load  = d_load;
    iss_rs1      = d_rs1;    iss_rs2   = d_rs2;     iss_rd = d_rd;
    dump_req     = d_dump;
    if (d_rst) exp_dump_q.delete();
    lsu_go    = !d_rst && d_lsu_v && idle;
    exu_go    = !d_rst && d_exu_v && !d_lsu_v && idle;
    exp_stall = d_iv && (!idle || is_busy(d_rs1) || is_busy(d_rs2) || is_busy(d_rd) ||
                         (d_load && any_busy()));
    if (lsu_go && d_lsu_rd != 5'd0) exp_wr_q.push_back({d_lsu_rd, d_lsu_d});
    if (exu_go && d_exu_rd != 5'd0) exp_wr_q.push_back({d_exu_rd, d_exu_d});
    @(negedge clk);
    if (d_rst) begin
      chk("rst_rf_we", rf_we, 0);
      chk("rst_dump_valid", dump_valid, 0);
      chk("rst_dump_idx", dump_idx, 0);
      chk("rst_dump_data", dump_data, 0);
    end else begin
      chk("lsu_ready", lsu_wb_ready, idle);
      chk("exu_ready", exu_wb_ready, idle && !d_lsu_v);
      chk("iss_stall", iss_stall, exp_stall);
      chk("dump_busy", dump_busy, !idle);
    end
    @(posedge clk);
    #1;
    if (d_rst) begin
      dump_left = 0;
      pend.delete();
      for (int i = 0; i < 32; i++) shadow[i] = '0;
      d_lsu_v = 1'b0;
      d_exu_v = 1'b0;
    end else begin
      if (lsu_go) begin
        for (int k = 0; k < pend.size(); k++) begin
          if (pend[k] == d_lsu_rd) begin pend.delete(k); break; end
        end
        if (d_lsu_rd != 5'd0) shadow[d_lsu_rd] = d_lsu_d;
        d_lsu_v = 1'b0;
      end
      if (exu_go) begin
        if (d_exu_rd != 5'd0) shadow[d_exu_rd] = d_exu_d;
        d_exu_v = 1'b0;
      end
      if (d_iv && !exp_stall && d_load) pend.push_back(d_rd);
      if (dump_left > 0) dump_left--;
      else if (d_dump) begin
        dump_left = 33;
        for (int i = 0; i < 32; i++) exp_dump_q.push_back({5'(i), shadow[i]});
      end
    end
  endtask

  task automatic issue(input logic v, input logic ld, input logic [4:0] r1,
                       input logic [4:0] r2, input logic [4:0] rd);
    d_iv = v; d_load = ld; d_rs1 = r1; d_rs2 = r2; d_rd = rd;
  endtask

  // ---------------- monitor ----------------
  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (rf_we === 1'b1) begin
        if (exp_wr_q.size() == 0) begin
          total++; bad++;
          $display("FAIL rf_write_unexpected: got x%0d=%0h expected no write", rf_waddr, rf_wdata);
        end else begin
          chk("rf_write", {rf_waddr, rf_wdata}, exp_wr_q.pop_front());
        end
      end
      if (dump_valid === 1'b1) begin
        if (exp_dump_q.size() == 0) begin
          total++; bad++;
          $display("FAIL dump_beat_unexpected: got idx %0d data %0h expected no beat", dump_idx, dump_data);
        end else begin
          logic [36:0] e;
          e = exp_dump_q.pop_front();
          chk("dump_beat", {dump_idx, dump_data}, e);
          if (e[36:32] != 5'd0) chk("dump_consecutive", cyc, last_beat_cyc + 1);
          last_beat_cyc = cyc;
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // ---------------- test sequence ----------------
  initial begin
    rst = 1'b1;
    exu_wb_valid = 0; lsu_wb_valid = 0; iss_valid = 0; iss_load = 0; dump_req = 0;
    exu_wb_rd = 0; lsu_wb_rd = 0; iss_rs1 = 0; iss_rs2 = 0; iss_rd = 0;
    exu_wb_data = 0; lsu_wb_data = 0;
    d_rst = 1; d_exu_v = 0; d_lsu_v = 0; d_dump = 0;
    d_exu_rd = 0; d_lsu_rd = 0; d_exu_d = 0; d_lsu_d = 0;
    issue(0, 0, 0, 0, 0);
    for (int i = 0; i < 32; i++) shadow[i] = '0;

    repeat (3) step();
    d_rst = 0;
    step();
    chk("idle_after_reset", dbg_state, DS_IDLE);

    // Simultaneous EXU and LSU: LSU first, EXU the following cycle.
    d_exu_v = 1; d_exu_rd = 5; d_exu_d = 32'h11;
    d_lsu_v = 1; d_lsu_rd = 6; d_lsu_d = 32'h22;
    step(); step(); step();

    // x0 write completes without touching the register file.
    d_exu_v = 1; d_exu_rd = 0; d_exu_d = 32'hDEADBEEF;
    step(); step();

    // Load to x7, then a dependent issue stalls until the load returns.
    issue(1, 1, 0, 0, 7); step();
    issue(1, 0, 7, 0, 8); step(); step(); step();
    d_lsu_v = 1; d_lsu_rd = 7; d_lsu_d = 32'h77;
    step(); step();
    issue(0, 0, 0, 0, 0);

    // Preload xi = i*4 and dump; a second request mid-dump is ignored.
    for (int i = 1; i < 32; i++) begin
      d_exu_v = 1; d_exu_rd = 5'(i); d_exu_d = 32'(i * 4);
      step();
    end
    d_dump = 1; step(); d_dump = 0;
    for (int i = 0; i < 35; i++) begin
      d_dump = (i == 9);
      step();
    end
    d_dump = 0;

    // Pending LSU writeback held off while the dump runs.
    issue(1, 1, 0, 0, 12); step(); issue(0, 0, 0, 0, 0);
    d_dump = 1; step(); d_dump = 0;
    d_lsu_v = 1; d_lsu_rd = 12; d_lsu_d = 32'hABCD1234;
    repeat (36) step();

    // Random traffic.
    for (int n = 0; n < 800; n++) begin
      if (!d_exu_v && $urandom_range(0, 1) == 1) begin
        d_exu_v = 1; d_exu_rd = 5'($urandom_range(0, 31)); d_exu_d = $urandom;
      end
      if (!d_lsu_v && pend.size() > 0 && $urandom_range(0, 2) == 0) begin
        d_lsu_v = 1; d_lsu_rd = pend[0]; d_lsu_d = $urandom;
      end
      issue($urandom_range(0, 1) == 1, $urandom_range(0, 2) == 0,
            5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
      d_dump = ($urandom_range(0, 59) == 0);
      step();
    end
    issue(0, 0, 0, 0, 0);
    d_dump = 0;

    // Settle: return all outstanding loads and let any dump finish.
    for (int n = 0; n < 200 && (pend.size() > 0 || dump_left > 0 || d_exu_v || d_lsu_v); n++) begin
      if (!d_lsu_v && pend.size() > 0) begin
        d_lsu_v = 1; d_lsu_rd = pend[0]; d_lsu_d = $urandom;
      end
      step();
    end

    // Reset in the middle of a dump with a load outstanding.
    issue(1, 1, 0, 0, 9); step(); issue(0, 0, 0, 0, 0);
    d_dump = 1; step(); d_dump = 0;
    repeat (11) step();
    d_rst = 1; step(); step(); d_rst = 0;
    issue(1, 0, 9, 9, 9); step();
    chk("idle_after_abort", dbg_state, DS_IDLE);
    issue(1, 1, 0, 0, 9); step();
    issue(0, 0, 0, 0, 0);
    d_lsu_v = 1; d_lsu_rd = 9; d_lsu_d = 32'h99;
    repeat (40) step();

    chk("exp_wr_drained", exp_wr_q.size(), 0);
    chk("exp_dump_drained", exp_dump_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
